// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the attopu core. It sits directly in front of the
// instruction decoder.
//
// The unit owns the program counter. It reads instruction memory with a
// request/acknowledge handshake and holds each fetched 16-bit word in a stable
// register until the decoder retires it. On retire, the decoder's nextPCSel
// chooses the next PC: increment, PC-relative branch, or register jump.
//
// Ports
//   clk          in   1   single clock, rising-edge active
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   instruction memory read request
//   imem_addr    out 16   read address (always the pc register)
//   imem_ack     in   1   imem_rdata valid this cycle (honoured only while requesting)
//   imem_rdata   in  16   instruction word from memory
//   instruction  out 16   registered instruction word for the decoder
//   instr_valid  out  1   instruction holds a fetched, not-yet-retired word
//   pc           out 16   address of the current or in-flight instruction
//   nextPCSel    in   2   00: pc+1, 01: pc+branch_addr, 1x: reg_target
//   branch_addr  in  16   sign-extended offset, relative to the branching instruction
//   reg_target   in  16   register-file jump target
//   retire       in   1   decoder finished the current word (honoured only while valid)
//   stall        in   1   blocks the start of a new fetch
//
// Every output is either a register or a decode of the state register. No
// input reaches an output through combinational logic.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instruction,
   output logic        instr_valid,
   output logic [15:0] pc,
   input  logic [1:0]  nextPCSel,
   input  logic [15:0] branch_addr,
   input  logic [15:0] reg_target,
   input  logic        retire,
   input  logic        stall
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // waiting for stall to drop before fetching
      ST_FETCH = 2'd1,   // request raised and waiting for ack
      ST_HOLD  = 2'd2    // word presented to the decoder, waiting for retire
   } state_e;

   typedef enum logic [1:0] {
      SEL_INC    = 2'b00,
      SEL_BRANCH = 2'b01
      // 2'b10 and 2'b11 both select the register target.
   } pc_sel_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] next_pc;

   // ---------------------------------------------------------------------------
   // Next-PC selection. This is evaluated every cycle from the current pc, but
   // it is only loaded on a retire edge. The select and operand inputs
   // therefore matter only in that cycle. All arithmetic wraps modulo 2^16.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default value first. A path that
      // leaves a variable unassigned would infer a latch.
      next_pc = reg_target;
      unique case (nextPCSel)
         SEL_INC:    next_pc = pc_q + 16'd1;
         SEL_BRANCH: next_pc = pc_q + branch_addr;
         default:    next_pc = reg_target;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic.
   // - A request, once raised, is held until ack. Stall is only examined when
   //   deciding whether to start a fetch.
   // - imem_ack outside FETCH and retire outside HOLD fall through to the
   //   defaults, so they cannot disturb the instruction or pc registers.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!stall) state_d = ST_FETCH;
         end

         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (retire) begin
               pc_d = next_pc;
               // Go straight back to FETCH when nothing is stalling. This
               // gives the two-cycle best-case instruction rate.
               state_d = stall ? ST_IDLE : ST_FETCH;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset is asynchronous, so asserting rst_n mid-fetch
   // clears the outputs at once and drops any ack still in flight.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 16'h0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only. Every
         // register then sees the values from before the edge, whatever order
         // the statements appear in.
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: these are registers, or decodes of the state register.
   // ---------------------------------------------------------------------------
   assign imem_req    = (state_q == ST_FETCH);
   assign instr_valid = (state_q == ST_HOLD);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed stimulus for fetch_unit with a scoreboard.
//
// Scoreboard flow:
//   - Whenever the driver acks a fetch, it pushes the expected
//     {pc, instruction} pair into a queue.
//   - A separate monitor pops one entry each time instr_valid rises and
//     compares it with the DUT.
//
// Immediate properties are checked inline by the driver. These are the reset
// values, request stability, stray handshakes, stall and asynchronous reset.
//
// The driver drives inputs on the falling edge. All sampling happens on the
// falling edge, or just after the asynchronous reset is applied.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [15:0] RST_PC = 16'h0010;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instruction;
   logic        instr_valid;
   logic [15:0] pc;
   logic [1:0]  nextPCSel;
   logic [15:0] branch_addr;
   logic [15:0] reg_target;
   logic        retire;
   logic        stall;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t sb_q[$];

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .nextPCSel   (nextPCSel),
      .branch_addr (branch_addr),
      .reg_target  (reg_target),
      .retire      (retire),
      .stall       (stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global watchdog: the run must always end on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, wanted completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, wanted %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: on every rising edge of instr_valid, compare the DUT's pc and
   // instruction with the next expected pair from the scoreboard.
   // ---------------------------------------------------------------------------
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got instruction %h at pc %h, wanted none", instruction, pc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_pc", pc, e.pc);
               check("sb_instr", instruction, e.instr);
            end
         end
         prev_valid = instr_valid;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks. Each one starts and ends just after a falling edge.
   // ---------------------------------------------------------------------------

   // Wait (bounded) for the request, then check the address. Hold ack low for
   // `waits` cycles while checking that the request stays stable, then ack.
   task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] rdata, input int waits);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: got imem_req=0 after 20 cycles, wanted 1 (addr %h)", exp_addr);
         return;
      end
      check("fetch_addr", imem_addr, exp_addr);
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         check("wait_req", {15'd0, imem_req}, 16'd1);
         check("wait_addr", imem_addr, exp_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      sb_q.push_back('{pc: exp_addr, instr: rdata});
      @(negedge clk);
      imem_ack = 1'b0;
      check("post_ack_req", {15'd0, imem_req}, 16'd0);
   endtask

   // Retire the held word with the given next-PC selection and stall level.
   task automatic do_retire(input logic [1:0] sel, input logic [15:0] br,
                            input logic [15:0] rt, input logic stall_v);
      check("retire_when_valid", {15'd0, instr_valid}, 16'd1);
      retire      = 1'b1;
      nextPCSel   = sel;
      branch_addr = br;
      reg_target  = rt;
      stall       = stall_v;
      @(negedge clk);
      retire      = 1'b0;
      // Scramble the selection inputs: they must only matter at the retire edge.
      nextPCSel   = 2'b01;
      branch_addr = 16'h1234;
      reg_target  = 16'hBEEF;
      check("retire_valid_drop", {15'd0, instr_valid}, 16'd0);
      check("retire_req", {15'd0, imem_req}, {15'd0, ~stall_v});
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 16'h0000;
      nextPCSel   = 2'b00;
      branch_addr = 16'h0000;
      reg_target  = 16'h0000;
      retire      = 1'b0;
      stall       = 1'b0;

      // Reset values.
      @(negedge clk);
      #1;
      check("rst_req", {15'd0, imem_req}, 16'd0);
      check("rst_valid", {15'd0, instr_valid}, 16'd0);
      check("rst_pc", pc, RST_PC);
      check("rst_instr", instruction, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // First fetch, acked with no wait state.
      check("first_req", {15'd0, imem_req}, 16'd1);
      do_fetch(16'h0010, 16'h4005, 0);

      // Stray ack in HOLD: the instruction must not change.
      imem_ack   = 1'b1;
      imem_rdata = 16'hDEAD;
      @(negedge clk);
      imem_ack = 1'b0;
      check("stray_ack_instr", instruction, 16'h4005);
      check("stray_ack_valid", {15'd0, instr_valid}, 16'd1);

      // Sequential fetch with wrap: FFFF -> 0000 -> 0001 -> 0002.
      do_retire(2'b10, 16'h0000, 16'hFFFF, 1'b0);
      do_fetch(16'hFFFF, 16'h1111, 0);
      do_retire(2'b00, 16'h0000, 16'h0000, 1'b0);
      do_fetch(16'h0000, 16'h2222, 1);
      do_retire(2'b00, 16'h0000, 16'h0000, 1'b0);
      do_fetch(16'h0001, 16'h2223, 0);
      do_retire(2'b00, 16'h0000, 16'h0000, 1'b0);
      do_fetch(16'h0002, 16'h2224, 0);

      // Jump to 0x0020, then issue a stray retire while in FETCH.
      do_retire(2'b10, 16'h0000, 16'h0020, 1'b0);
      retire     = 1'b1;
      nextPCSel  = 2'b11;
      reg_target = 16'h5555;
      @(negedge clk);
      retire = 1'b0;
      check("stray_retire_pc", pc, 16'h0020);
      check("stray_retire_req", {15'd0, imem_req}, 16'd1);
      do_fetch(16'h0020, 16'h3333, 0);

      // Backward branch: 0x0020 + 0xFFFC = 0x001C, with three wait states.
      do_retire(2'b01, 16'hFFFC, 16'h0000, 1'b0);
      do_fetch(16'h001C, 16'h3334, 3);

      // Register jump selected with 11.
      do_retire(2'b11, 16'h0000, 16'h0ABC, 1'b0);
      do_fetch(16'h0ABC, 16'h3335, 0);

      // Stall at retire: stay in IDLE for as long as stall is high.
      do_retire(2'b00, 16'h0000, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_req", {15'd0, imem_req}, 16'd0);
         check("stall_valid", {15'd0, instr_valid}, 16'd0);
      end
      check("stall_pc", pc, 16'h0ABD);
      stall = 1'b0;
      @(negedge clk);
      check("unstall_req", {15'd0, imem_req}, 16'd1);

      // Stall raised mid-FETCH: the request must still complete.
      stall = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midfetch_stall_req", {15'd0, imem_req}, 16'd1);
      do_fetch(16'h0ABD, 16'h6666, 0);
      stall = 1'b0;

      // Asynchronous reset in HOLD with pc = 0x0042.
      do_retire(2'b10, 16'h0000, 16'h0042, 1'b0);
      do_fetch(16'h0042, 16'h7777, 0);
      check("pre_reset_pc", pc, 16'h0042);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {15'd0, instr_valid}, 16'd0);
      check("async_rst_req", {15'd0, imem_req}, 16'd0);
      check("async_rst_pc", pc, RST_PC);
      check("async_rst_instr", instruction, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_fetch(RST_PC, 16'h0BAD, 0);
      @(negedge clk);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending entries, wanted 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
